// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for fetch and decode: NOP word, reset PC, the LRLI
// two-word opcode pattern and the opcodes that redirect the PC.
package cpu_isa_pkg;

    localparam logic [15:0] NOP_WORD     = 16'h0000;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;
    localparam logic [15:0] LRLI_MASK    = 16'hFE00;
    localparam logic [15:0] LRLI_MATCH   = 16'h8400;

    // Opcode field is word[15:9]; LRLI occupies 7'h42.
    localparam logic [6:0] OP_LRLI   = 7'h42;
    localparam logic [6:0] OP_JUMP   = 7'h60;
    localparam logic [6:0] OP_JUMPR  = 7'h61;
    localparam logic [6:0] OP_BRZ    = 7'h62;
    localparam logic [6:0] OP_BRN    = 7'h63;
    localparam logic [6:0] OP_CALL   = 7'h64;
    localparam logic [6:0] OP_RETURN = 7'h65;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXT   = 1'b1
    } fetch_state_e;

    function automatic logic is_ext_word(input logic [15:0] word,
                                         input logic [15:0] mask,
                                         input logic [15:0] match);
        return (word & mask) == match;
    endfunction

endpackage

// File: rtl/fetch_pc_ctr.sv
// 8-bit fetch PC register: redirect load has priority, then hold, then increment.
// Arithmetic wraps modulo 256.
module fetch_pc_ctr
    import cpu_isa_pkg::*;
#(
    parameter logic [7:0] RESET_PC = RESET_PC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_pc_i,
    input  logic       inc_i,
    input  logic       hold_i,
    output logic [7:0] pc_o,
    output logic [7:0] pc_plus1_o
);

    logic [7:0] pc_q;
    logic [7:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (!hold_i && inc_i) begin
            pc_d = pc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus1_o = pc_q + 8'd1;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program-ROM fetch front end: drives the fetch address, assembles LRLI
// opcode+literal pairs into one issue slot and flushes on execute redirects.
module instr_fetch_unit
    import cpu_isa_pkg::*;
#(
    parameter logic [7:0]  RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] EXT_MASK  = LRLI_MASK,
    parameter logic [15:0] EXT_MATCH = LRLI_MATCH
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  pc_out,
    input  logic [15:0] instr_in,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic [15:0] ir,
    output logic [15:0] ir_ext,
    output logic        ir_is_ext,
    output logic [7:0]  ir_pc,
    output logic [7:0]  link_pc,
    output logic        ir_valid,
    input  logic        ir_ready
);

    fetch_state_e state_q, state_d;
    logic [15:0]  ir_q, ir_d;
    logic [15:0]  ir_ext_q, ir_ext_d;
    logic         ir_is_ext_q, ir_is_ext_d;
    logic [7:0]   ir_pc_q, ir_pc_d;
    logic [7:0]   link_pc_q, link_pc_d;
    logic         ir_valid_q, ir_valid_d;

    logic       pc_load;
    logic       pc_inc;
    logic       pc_hold;
    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic       slot_free;
    logic       word_is_ext;

    fetch_pc_ctr #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_pc_i  (redirect_pc),
        .inc_i      (pc_inc),
        .hold_i     (pc_hold),
        .pc_o       (pc),
        .pc_plus1_o (pc_plus1)
    );

    assign slot_free   = !ir_valid_q || ir_ready;
    assign word_is_ext = is_ext_word(instr_in, EXT_MASK, EXT_MATCH);
    assign pc_hold     = !pc_inc && !pc_load;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_ext_d    = ir_ext_q;
        ir_is_ext_d = ir_is_ext_q;
        ir_pc_d     = ir_pc_q;
        link_pc_d   = link_pc_q;
        ir_valid_d  = ir_valid_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;

        if (redirect_valid) begin
            // Drops any held or half-assembled instruction.
            pc_load     = 1'b1;
            ir_valid_d  = 1'b0;
            ir_is_ext_d = 1'b0;
            state_d     = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (fetch_en && slot_free) begin
                        ir_d    = instr_in;
                        ir_pc_d = pc;
                        pc_inc  = 1'b1;
                        if (word_is_ext) begin
                            ir_valid_d = 1'b0;
                            state_d    = ST_EXT;
                        end else begin
                            ir_valid_d  = 1'b1;
                            ir_is_ext_d = 1'b0;
                            link_pc_d   = pc_plus1;
                        end
                    end
                end
                ST_EXT: begin
                    if (fetch_en) begin
                        ir_ext_d    = instr_in;
                        pc_inc      = 1'b1;
                        ir_is_ext_d = 1'b1;
                        link_pc_d   = pc_plus1;
                        ir_valid_d  = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            ir_q        <= NOP_WORD;
            ir_ext_q    <= 16'h0000;
            ir_is_ext_q <= 1'b0;
            ir_pc_q     <= 8'h00;
            link_pc_q   <= 8'h00;
            ir_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_ext_q    <= ir_ext_d;
            ir_is_ext_q <= ir_is_ext_d;
            ir_pc_q     <= ir_pc_d;
            link_pc_q   <= link_pc_d;
            ir_valid_q  <= ir_valid_d;
        end
    end

    assign pc_out    = pc;
    assign ir        = ir_q;
    assign ir_ext    = ir_ext_q;
    assign ir_is_ext = ir_is_ext_q;
    assign ir_pc     = ir_pc_q;
    assign link_pc   = link_pc_q;
    assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner
// sequences, then random traffic checked against an instruction-stream model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc_out;
    logic [15:0] instr_in;
    logic        fetch_en;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [15:0] ir;
    logic [15:0] ir_ext;
    logic        ir_is_ext;
    logic [7:0]  ir_pc;
    logic [7:0]  link_pc;
    logic        ir_valid;
    logic        ir_ready;

    logic [15:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign instr_in = rom[pc_out];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc_out         (pc_out),
        .instr_in       (instr_in),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir             (ir),
        .ir_ext         (ir_ext),
        .ir_is_ext      (ir_is_ext),
        .ir_pc          (ir_pc),
        .link_pc        (link_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready)
    );

    typedef struct {
        logic        fe;
        logic        rdy;
        logic [7:0]  pc;
        logic        vld;
        logic [15:0] ir;
        logic [7:0]  ir_pc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [7:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick();
        redirect_valid = 1'b0;
    endtask

    function automatic logic is_ext(input logic [15:0] w);
        return (w & 16'hFE00) == 16'h8400;
    endfunction

    logic [7:0]  ptr;
    logic [7:0]  p_pc;
    logic [7:0]  p_irpc;
    logic [15:0] p_ir;
    logic        p_valid;
    logic [15:0] w;
    logic [15:0] exp_word;
    logic [7:0]  a1;
    logic [7:0]  exp_link;
    logic        fe_r, rdy_r, rv_r;
    logic [7:0]  rpc_r;
    int          n_issued;

    initial begin
        rst            = 1'b0;
        fetch_en       = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[4] = 16'h1004;
        rom[5] = 16'h1005;
        rom[6] = 16'h1006;
        rom[7] = 16'h2007;
        rom[8] = 16'h2008;
        rom[8'h0B] = 16'h8500;
        rom[8'h0C] = 16'hC001;
        rom[8'h0D] = 16'h300D;
        rom[8'h80] = 16'h4080;

        tbl[0]  = '{1'b1, 1'b1, 8'h01, 1'b1, 16'h0000, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'h02, 1'b1, 16'h0000, 8'h01};
        tbl[2]  = '{1'b1, 1'b1, 8'h03, 1'b1, 16'h0000, 8'h02};
        tbl[3]  = '{1'b1, 1'b1, 8'h04, 1'b1, 16'h0000, 8'h03};
        tbl[4]  = '{1'b1, 1'b1, 8'h05, 1'b1, 16'h1004, 8'h04};
        tbl[5]  = '{1'b1, 1'b0, 8'h05, 1'b1, 16'h1004, 8'h04};
        tbl[6]  = '{1'b1, 1'b0, 8'h05, 1'b1, 16'h1004, 8'h04};
        tbl[7]  = '{1'b1, 1'b0, 8'h05, 1'b1, 16'h1004, 8'h04};
        tbl[8]  = '{1'b1, 1'b1, 8'h06, 1'b1, 16'h1005, 8'h05};
        tbl[9]  = '{1'b1, 1'b1, 8'h07, 1'b1, 16'h1006, 8'h06};
        tbl[10] = '{1'b0, 1'b0, 8'h07, 1'b1, 16'h1006, 8'h06};
        tbl[11] = '{1'b1, 1'b1, 8'h08, 1'b1, 16'h2007, 8'h07};

        @(posedge clk);
        #1;
        do_reset();
        chk("rst_pc_out",    32'(pc_out),    32'h00);
        chk("rst_ir_valid",  32'(ir_valid),  32'h0);
        chk("rst_ir",        32'(ir),        32'h0000);
        chk("rst_ir_ext",    32'(ir_ext),    32'h0000);
        chk("rst_ir_is_ext", 32'(ir_is_ext), 32'h0);
        chk("rst_ir_pc",     32'(ir_pc),     32'h00);
        chk("rst_link_pc",   32'(link_pc),   32'h00);

        for (int i = 0; i < 12; i++) begin
            fetch_en = tbl[i].fe;
            ir_ready = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d_pc_out", i),   32'(pc_out),   32'(tbl[i].pc));
            chk($sformatf("tbl%0d_ir_valid", i), 32'(ir_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_ir", i),       32'(ir),       32'(tbl[i].ir));
            chk($sformatf("tbl%0d_ir_pc", i),    32'(ir_pc),    32'(tbl[i].ir_pc));
        end

        // Two-word instruction at 0x0B issues once, then the next word.
        fetch_en = 1'b1;
        ir_ready = 1'b1;
        pulse_redirect(8'h0B);
        chk("ext_redir_pc", 32'(pc_out), 32'h0B);
        chk("ext_redir_vld", 32'(ir_valid), 32'h0);
        tick();
        chk("ext_op_vld", 32'(ir_valid), 32'h0);
        chk("ext_op_pc", 32'(pc_out), 32'h0C);
        tick();
        chk("ext_vld", 32'(ir_valid), 32'h1);
        chk("ext_ir", 32'(ir), 32'h8500);
        chk("ext_ir_ext", 32'(ir_ext), 32'hC001);
        chk("ext_is_ext", 32'(ir_is_ext), 32'h1);
        chk("ext_ir_pc", 32'(ir_pc), 32'h0B);
        chk("ext_link", 32'(link_pc), 32'h0D);
        chk("ext_pc_out", 32'(pc_out), 32'h0D);
        tick();
        chk("ext_next_ir", 32'(ir), 32'h300D);
        chk("ext_next_is_ext", 32'(ir_is_ext), 32'h0);
        chk("ext_next_ir_pc", 32'(ir_pc), 32'h0D);
        chk("ext_next_link", 32'(link_pc), 32'h0E);

        // Redirect while waiting for the literal.
        pulse_redirect(8'h0B);
        tick();
        chk("rx_in_ext_vld", 32'(ir_valid), 32'h0);
        pulse_redirect(8'h80);
        chk("rx_vld", 32'(ir_valid), 32'h0);
        chk("rx_pc_out", 32'(pc_out), 32'h80);
        tick();
        chk("rx_tgt_vld", 32'(ir_valid), 32'h1);
        chk("rx_tgt_ir_pc", 32'(ir_pc), 32'h80);
        chk("rx_tgt_ir", 32'(ir), 32'h4080);
        chk("rx_tgt_is_ext", 32'(ir_is_ext), 32'h0);

        // Two-word opcode at 0xFF takes its literal from 0x00.
        rom[8'h00] = 16'h5A5A;
        rom[8'hFF] = 16'h8455;
        pulse_redirect(8'hFF);
        chk("wrap_pc_ff", 32'(pc_out), 32'hFF);
        tick();
        chk("wrap_pc_00", 32'(pc_out), 32'h00);
        tick();
        chk("wrap_vld", 32'(ir_valid), 32'h1);
        chk("wrap_ir_pc", 32'(ir_pc), 32'hFF);
        chk("wrap_ir", 32'(ir), 32'h8455);
        chk("wrap_ir_ext", 32'(ir_ext), 32'h5A5A);
        chk("wrap_link", 32'(link_pc), 32'h01);
        chk("wrap_pc_out", 32'(pc_out), 32'h01);

        // Asynchronous reset while stalled.
        ir_ready = 1'b0;
        tick();
        chk("stall_vld", 32'(ir_valid), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", 32'(pc_out), 32'h00);
        chk("async_rst_vld", 32'(ir_valid), 32'h0);
        chk("async_rst_ir", 32'(ir), 32'h0000);
        chk("async_rst_is_ext", 32'(ir_is_ext), 32'h0);
        rst = 1'b0;
        ir_ready = 1'b1;
        tick();
        chk("post_rst_ir_pc", 32'(ir_pc), 32'h00);
        chk("post_rst_ir", 32'(ir), 32'h5A5A);
        chk("post_rst_pc", 32'(pc_out), 32'h01);

        // Random traffic against the instruction-stream model: every accepted
        // issue must be the instruction starting at ptr; ptr follows link or redirect.
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if ($urandom_range(3) == 0) w = (w & 16'h01FF) | 16'h8400;
            rom[i] = w;
        end
        fetch_en       = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        do_reset();
        ptr      = 8'h00;
        n_issued = 0;
        for (int c = 0; c < 3000; c++) begin
            fe_r  = ($urandom_range(9) != 0);
            rdy_r = fe_r && ($urandom_range(9) < 7);
            rv_r  = ($urandom_range(19) == 0);
            rpc_r = 8'($urandom);
            fetch_en       = fe_r;
            ir_ready       = rdy_r;
            redirect_valid = rv_r;
            redirect_pc    = rpc_r;
            p_pc    = pc_out;
            p_ir    = ir;
            p_irpc  = ir_pc;
            p_valid = ir_valid;
            if (ir_valid && rdy_r) begin
                exp_word = rom[ptr];
                a1       = ptr + 8'd1;
                exp_link = is_ext(exp_word) ? (ptr + 8'd2) : a1;
                chk("rnd_ir", 32'(ir), 32'(exp_word));
                chk("rnd_ir_pc", 32'(ir_pc), 32'(ptr));
                chk("rnd_is_ext", 32'(ir_is_ext), 32'(is_ext(exp_word)));
                chk("rnd_link", 32'(link_pc), 32'(exp_link));
                if (is_ext(exp_word)) chk("rnd_ir_ext", 32'(ir_ext), 32'(rom[a1]));
                ptr = exp_link;
                n_issued++;
            end
            if (rv_r) ptr = rpc_r;
            tick();
            if (rv_r) begin
                chk("rnd_redir_pc", 32'(pc_out), 32'(rpc_r));
                chk("rnd_redir_vld", 32'(ir_valid), 32'h0);
            end else if (p_valid && !rdy_r) begin
                chk("rnd_stall_ir", 32'(ir), 32'(p_ir));
                chk("rnd_stall_ir_pc", 32'(ir_pc), 32'(p_irpc));
                chk("rnd_stall_pc", 32'(pc_out), 32'(p_pc));
                chk("rnd_stall_vld", 32'(ir_valid), 32'h1);
            end else if (!fe_r) begin
                chk("rnd_freeze_pc", 32'(pc_out), 32'(p_pc));
            end
        end
        redirect_valid = 1'b0;
        chk("rnd_liveness", 32'(n_issued > 500), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
